lane_result_framer: RTL and testbench



---
 rtl/lane_pkg.sv | 23 ++
 rtl/sync_fifo.sv | 47 ++++
 rtl/lane_result_framer.sv | 133 +++++++++++++
 tb/tb_lane_result_framer.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lane_pkg.sv
// Shared types for the lane-detection result path.
//   lane_result_t     : one lane result, {center, conf}
//   SYNC_BYTE_DEFAULT : default first byte of every serial frame
//   frame_state_e     : byte position of the framer FSM
package lane_pkg;

  typedef struct packed {
    logic [7:0] center;
    logic [7:0] conf;
  } lane_result_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_SEQ,
    ST_CENTER,
    ST_CONF,
    ST_CSUM
  } frame_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO.
//   clk, rst     : clock, asynchronous active-high reset (empties the FIFO)
//   push, wdata  : write; caller guarantees !full, or a pop in the same cycle
//   pop          : read; caller guarantees !empty
//   rdata        : head entry, valid whenever !empty
//   full, empty  : occupancy flags
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // One extra wrap bit distinguishes full from empty when indices match.
  logic [AW:0]      wr_ptr, rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Push into a full FIFO only happens together with a pop; the head slot
  // being overwritten has already been read combinationally this cycle.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/lane_result_framer.sv
// Buffers lane results and serializes each into a 5-byte frame:
//   SYNC_BYTE, seq, center, conf, csum (csum = seq ^ center ^ conf).
//   clk, rst                   : clock, asynchronous active-high reset
//   result_valid/center/conf   : one-cycle result pulse from the controller
//   out_data/out_valid/out_ready : byte stream toward the UART
//   busy                       : frame in progress or results buffered
//   drop_count                 : saturating count of results lost to a full FIFO
module lane_result_framer
  import lane_pkg::*;
#(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       result_valid,
  input  logic [7:0] result_center,
  input  logic [7:0] result_conf,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic [7:0] drop_count
);

  lane_result_t fifo_wdata, fifo_rdata;
  logic         fifo_full, fifo_empty, push, pop, drop, accept;

  frame_state_e state_q, state_d;
  lane_result_t frame_q, frame_d;
  logic [7:0]   seq_q, seq_d, csum_q, csum_d, data_q, data_d;
  logic         valid_q, valid_d;
  logic [7:0]   drop_q;

  assign fifo_wdata = '{center: result_center, conf: result_conf};

  // A full FIFO still takes a result when the head leaves in the same cycle.
  assign push   = result_valid && (!fifo_full || pop);
  assign drop   = result_valid && fifo_full && !pop;
  assign accept = valid_q && out_ready;

  sync_fifo #(
    .WIDTH ($bits(lane_result_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Each state names the byte currently on out_data; out_data is loaded
  // with the next byte on the same edge that advances the state.
  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    seq_d   = seq_q;
    csum_d  = csum_q;
    data_d  = data_q;
    valid_d = valid_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          frame_d = fifo_rdata;
          csum_d  = seq_q ^ fifo_rdata.center ^ fifo_rdata.conf;
          data_d  = SYNC_BYTE;
          valid_d = 1'b1;
          state_d = ST_SYNC;
        end
      end
      ST_SYNC: if (accept) begin
        data_d  = seq_q;
        state_d = ST_SEQ;
      end
      ST_SEQ: if (accept) begin
        data_d  = frame_q.center;
        state_d = ST_CENTER;
      end
      ST_CENTER: if (accept) begin
        data_d  = frame_q.conf;
        state_d = ST_CONF;
      end
      ST_CONF: if (accept) begin
        data_d  = csum_q;
        state_d = ST_CSUM;
      end
      ST_CSUM: if (accept) begin
        valid_d = 1'b0;
        seq_d   = seq_q + 8'd1;
        state_d = ST_IDLE;
      end
      default: begin
        valid_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      frame_q <= '0;
      seq_q   <= '0;
      csum_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      seq_q   <= seq_d;
      csum_q  <= csum_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           drop_q <= '0;
    else if (drop && drop_q != 8'hFF)  drop_q <= drop_q + 8'd1;
  end

  assign out_data   = data_q;
  assign out_valid  = valid_q;
  assign busy       = (state_q != ST_IDLE) || !fifo_empty;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_lane_result_framer.sv
module tb_lane_result_framer;
  import lane_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       result_valid = 1'b0;
  logic [7:0] result_center = '0;
  logic [7:0] result_conf = '0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       busy;
  logic [7:0] drop_count;

  lane_result_framer #(.FIFO_DEPTH(4), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .rst(rst),
    .result_valid(result_valid), .result_center(result_center), .result_conf(result_conf),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference scoreboard ----------------
  // Expected frames are the submitted results in order; seq counts frames
  // since reset modulo 256 and csum is the XOR of seq, center and conf.
  lane_result_t exp_q[$];
  int           frames = 0;
  logic [7:0]   last_seq = '0;
  logic [7:0]   mseq = '0;
  logic [7:0]   fb [5];
  int           bi = 0;
  logic         stl = 1'b0;
  logic [7:0]   hld = '0;

  always @(negedge clk) begin
    if (rst) begin
      bi = 0; mseq = 8'h00; stl = 1'b0;
    end else begin
      if (stl) begin
        chk("stall_valid_held", {31'd0, out_valid}, 32'd1);
        chk("stall_data_held", {24'd0, out_data}, {24'd0, hld});
      end
      if (out_valid && out_ready) begin
        fb[bi] = out_data;
        bi++;
        stl = 1'b0;
        if (bi == 5) begin
          lane_result_t r;
          bi = 0;
          if (exp_q.size() == 0) begin
            chk("unexpected_frame", 32'd1, 32'd0);
          end else begin
            r = exp_q.pop_front();
            chk("frame_sync",   {24'd0, fb[0]}, 32'hA5);
            chk("frame_seq",    {24'd0, fb[1]}, {24'd0, mseq});
            chk("frame_center", {24'd0, fb[2]}, {24'd0, r.center});
            chk("frame_conf",   {24'd0, fb[3]}, {24'd0, r.conf});
            chk("frame_csum",   {24'd0, fb[4]}, {24'd0, mseq ^ r.center ^ r.conf});
          end
          last_seq = fb[1];
          frames++;
          mseq = mseq + 8'd1;
        end
      end else if (out_valid) begin
        stl = 1'b1;
        hld = out_data;
      end else begin
        stl = 1'b0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] c, input logic [7:0] f, input bit track);
    lane_result_t r;
    result_center = c;
    result_conf   = f;
    result_valid  = 1'b1;
    if (track) begin
      r.center = c; r.conf = f;
      exp_q.push_back(r);
    end
    tick();
    result_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    result_valid = 1'b0;
    out_ready = 1'b0;
    tick(); tick();
    exp_q.delete();
    frames = 0;
    rst = 1'b0;
    tick();
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    chk(name, {31'd0, busy}, 32'd0);
  endtask

  typedef struct {
    logic [7:0] center;
    logic [7:0] conf;
    logic [7:0] seq;
    logic [7:0] csum;
  } vec_t;

  vec_t tbl[6];

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    logic [7:0] exp_bytes [5];
    logic [7:0] got [$];
    bit         pat [4];
    int         n;
    int         pushed;

    tbl[0] = '{8'h0E, 8'hC8, 8'h00, 8'hC6};
    tbl[1] = '{8'h00, 8'h00, 8'h01, 8'h01};
    tbl[2] = '{8'h1D, 8'hFF, 8'h02, 8'hE0};
    tbl[3] = '{8'h07, 8'h55, 8'h03, 8'h51};
    tbl[4] = '{8'h10, 8'h10, 8'h04, 8'h04};
    tbl[5] = '{8'h1C, 8'h80, 8'h05, 8'h99};

    // Reset state
    rst = 1'b1;
    tick(); tick();
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_out_data",  {24'd0, out_data}, 32'd0);
    chk("reset_busy",      {31'd0, busy}, 32'd0);
    chk("reset_drop",      {24'd0, drop_count}, 32'd0);
    do_reset();

    // Table: exact per-cycle byte timing with out_ready held high
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      exp_bytes[0] = 8'hA5;
      exp_bytes[1] = tbl[i].seq;
      exp_bytes[2] = tbl[i].center;
      exp_bytes[3] = tbl[i].conf;
      exp_bytes[4] = tbl[i].csum;
      send(tbl[i].center, tbl[i].conf, 1'b1);
      chk("tbl_pre_valid", {31'd0, out_valid}, 32'd0);
      chk("tbl_pre_busy",  {31'd0, busy}, 32'd1);
      for (int k = 0; k < 5; k++) begin
        tick();
        chk($sformatf("tbl%0d_valid%0d", i, k), {31'd0, out_valid}, 32'd1);
        chk($sformatf("tbl%0d_byte%0d", i, k), {24'd0, out_data}, {24'd0, exp_bytes[k]});
      end
      tick();
      chk("tbl_post_valid", {31'd0, out_valid}, 32'd0);
      chk("tbl_post_busy",  {31'd0, busy}, 32'd0);
    end
    chk("tbl_frames", frames, 6);

    // Backpressure: ready pattern 1,0,0,1 repeating
    do_reset();
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    send(8'd14, 8'd200, 1'b1);
    n = 0;
    while (got.size() < 5 && n < 100) begin
      tick();
      out_ready = pat[n % 4];
      if (out_valid && out_ready) got.push_back(out_data);
      n++;
    end
    tick();
    out_ready = 1'b0;
    chk("bp_byte_count", got.size(), 5);
    exp_bytes[0] = 8'hA5; exp_bytes[1] = 8'h00; exp_bytes[2] = 8'h0E;
    exp_bytes[3] = 8'hC8; exp_bytes[4] = 8'hC6;
    for (int k = 0; k < 5 && k < got.size(); k++)
      chk($sformatf("bp_byte%0d", k), {24'd0, got[k]}, {24'd0, exp_bytes[k]});
    chk("bp_post_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_post_busy",  {31'd0, busy}, 32'd0);

    // Overflow: 6 back-to-back results with the sink stalled
    do_reset();
    for (int i = 0; i < 6; i++) begin
      result_center = 8'(i + 1);
      result_conf   = 8'(8'h30 + i);
      result_valid  = 1'b1;
      if (i < 5) exp_q.push_back('{center: 8'(i + 1), conf: 8'(8'h30 + i)});
      tick();
    end
    result_valid = 1'b0;
    chk("ovf_drop_count", {24'd0, drop_count}, 32'd1);
    repeat (3) tick();
    chk("ovf_stall_valid", {31'd0, out_valid}, 32'd1);
    chk("ovf_stall_data",  {24'd0, out_data}, 32'hA5);
    out_ready = 1'b1;
    wait_idle(200, "ovf_drain_timeout");
    chk("ovf_frames", frames, 5);
    chk("ovf_last_seq", {24'd0, last_seq}, 32'd4);
    chk("ovf_queue_empty", exp_q.size(), 0);

    // Drop counter saturation
    do_reset();
    for (int i = 0; i < 300; i++) send(8'(i % 30), 8'(i), 1'b0);
    chk("sat_drop_count", {24'd0, drop_count}, 32'hFF);

    // Push coinciding with the IDLE pop while the FIFO is full
    do_reset();
    for (int i = 0; i < 5; i++) send(8'(10 + i), 8'(8'h60 + i), 1'b1);
    chk("full_drop_before", {24'd0, drop_count}, 32'd0);
    out_ready = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!(busy && !out_valid) && n < 50);
    chk("full_idle_found", {31'd0, busy && !out_valid}, 32'd1);
    send(8'd29, 8'hEE, 1'b1);
    chk("full_pushpop_drop", {24'd0, drop_count}, 32'd0);
    wait_idle(200, "full_drain_timeout");
    chk("full_frames", frames, 6);
    chk("full_queue_empty", exp_q.size(), 0);

    // Sequence wrap over 257 frames
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 257; i++) begin
      send(8'($urandom_range(0, 29)), 8'($urandom), 1'b1);
      repeat (6) tick();
    end
    wait_idle(50, "wrap_drain_timeout");
    chk("wrap_frames", frames, 257);
    chk("wrap_last_seq", {24'd0, last_seq}, 32'd0);

    // Reset in the middle of a frame
    do_reset();
    out_ready = 1'b1;
    send(8'd5, 8'd77, 1'b0);
    repeat (4) tick();
    chk("mid_pre_valid", {31'd0, out_valid}, 32'd1);
    chk("mid_pre_data",  {24'd0, out_data}, 32'd77);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_data",  {24'd0, out_data}, 32'd0);
    chk("mid_rst_busy",  {31'd0, busy}, 32'd0);
    tick(); tick();
    exp_q.delete();
    frames = 0;
    rst = 1'b0;
    tick();
    send(8'd21, 8'd99, 1'b1);
    wait_idle(50, "mid_drain_timeout");
    chk("mid_frames", frames, 1);
    chk("mid_seq_restart", {24'd0, last_seq}, 32'd0);

    // Randomized traffic; outstanding results kept below FIFO_DEPTH so none drop
    do_reset();
    pushed = 0;
    for (int c = 0; c < 3000; c++) begin
      out_ready = ($urandom_range(0, 9) < 7);
      if ((pushed - frames) < 4 && $urandom_range(0, 2) == 0) begin
        result_center = 8'($urandom_range(0, 29));
        result_conf   = 8'($urandom);
        result_valid  = 1'b1;
        exp_q.push_back('{center: result_center, conf: result_conf});
        pushed++;
      end else begin
        result_valid = 1'b0;
      end
      tick();
    end
    result_valid = 1'b0;
    out_ready = 1'b1;
    wait_idle(200, "rand_drain_timeout");
    chk("rand_frames", frames, pushed);
    chk("rand_queue_empty", exp_q.size(), 0);
    chk("rand_drop_count", {24'd0, drop_count}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
